// File: rtl/ttrng_sampler.sv
// ttrng_sampler: health-tested TRNG byte sampler; a staged sample is pushed one edge later, out_valid the cycle after.
// A full FIFO with no pop drops the sample and sets overrun. Adaptive-proportion test compiled in with TTRNG_APT_EN.
module ttrng_sampler #(
    parameter int unsigned STARTUP    = 16,
    parameter int unsigned RCT_CUTOFF = 5,
    parameter int unsigned APT_WINDOW = 64,
    parameter int unsigned APT_CUTOFF = 13,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] number,
    input  logic       number_valid,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       health_fail,
    output logic [1:0] fail_code,
    output logic       overrun,
    input  logic       clear_fail
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {ST_STARTUP, ST_RUN, ST_FAIL} state_t;

    if (STARTUP < 1 || STARTUP > 255 || RCT_CUTOFF < 2 || RCT_CUTOFF > 15 ||
        APT_WINDOW < 16 || APT_WINDOW > 256 || APT_CUTOFF < 2 || APT_CUTOFF > APT_WINDOW ||
        FIFO_DEPTH < 2 || FIFO_DEPTH > 16) begin : g_bad_cfg
        $error("ttrng_sampler: parameter out of range");
    end

    state_t        state;
    logic          stg_vld;
    logic [7:0]    stg_dat;
    logic [7:0]    rct_prev;
    logic [3:0]    rct_cnt;
    logic [3:0]    rct_cnt_n;
    logic [7:0]    su_cnt;
    logic [7:0]    su_cnt_n;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          proc;
    logic          rct_fail;
    logic          apt_fail;
    logic          any_fail;
    logic          enter_fail;
    logic          full;
    logic          push;
    logic          push_ok;
    logic          pop;

    // A sample staged in the clear_fail cycle is discarded, and nothing is evaluated while disabled or failed.
    assign proc       = stg_vld && ena && (state != ST_FAIL) && !clear_fail;
    assign rct_cnt_n  = (rct_cnt != 4'd0 && stg_dat == rct_prev) ? rct_cnt + 4'd1 : 4'd1;
    assign rct_fail   = rct_cnt_n >= 4'(RCT_CUTOFF);
    assign su_cnt_n   = su_cnt + 8'd1;
    assign any_fail   = rct_fail || apt_fail;
    assign enter_fail = proc && any_fail;
    assign full       = (count == CW'(FIFO_DEPTH));
    assign pop        = out_ready && (count != '0);
    assign push       = proc && (state == ST_RUN) && !any_fail;
    assign push_ok    = push && (!full || pop);

    assign out_valid  = (count != '0) && (state != ST_FAIL);
    assign out_data   = mem[rd_ptr];

`ifdef TTRNG_APT_EN
    localparam int unsigned AIW = $clog2(APT_WINDOW);
    localparam int unsigned ACW = AIW + 1;

    logic [AIW-1:0] apt_idx;
    logic [7:0]     apt_ref;
    logic [ACW-1:0] apt_cnt;
    logic [ACW-1:0] apt_cnt_n;

    // apt_idx == 0 marks the first sample of a window, which becomes the reference.
    assign apt_cnt_n = (apt_idx == '0) ? ACW'(1)
                     : (stg_dat == apt_ref) ? apt_cnt + ACW'(1) : apt_cnt;
    assign apt_fail  = apt_cnt_n >= ACW'(APT_CUTOFF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            apt_idx <= '0;
            apt_ref <= 8'h00;
            apt_cnt <= '0;
        end else if (clear_fail && state == ST_FAIL) begin
            apt_idx <= '0;
            apt_cnt <= '0;
        end else if (proc) begin
            apt_idx <= apt_idx + AIW'(1);
            apt_cnt <= apt_cnt_n;
            if (apt_idx == '0) begin
                apt_ref <= stg_dat;
            end
        end
    end
`else
    assign apt_fail = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_STARTUP;
            stg_vld     <= 1'b0;
            stg_dat     <= 8'h00;
            rct_prev    <= 8'h00;
            rct_cnt     <= 4'd0;
            su_cnt      <= 8'd0;
            health_fail <= 1'b0;
            fail_code   <= 2'b00;
            overrun     <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem[i] <= 8'h00;
            end
        end else begin
            if (ena) begin
                stg_vld <= number_valid;
                if (number_valid) begin
                    stg_dat <= number;
                end
            end else if (clear_fail) begin
                stg_vld <= 1'b0;
            end

            if (enter_fail) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_ok) begin
                    mem[wr_ptr] <= stg_dat;
                    wr_ptr      <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (push_ok && !pop) begin
                    count <= count + CW'(1);
                end else if (!push_ok && pop) begin
                    count <= count - CW'(1);
                end
            end

            if (clear_fail) begin
                overrun <= 1'b0;
            end else if (push && full && !pop) begin
                overrun <= 1'b1;
            end

            case (state)
                ST_STARTUP, ST_RUN: begin
                    if (proc) begin
                        rct_prev <= stg_dat;
                        rct_cnt  <= rct_cnt_n;
                        if (any_fail) begin
                            state       <= ST_FAIL;
                            health_fail <= 1'b1;
                            fail_code   <= {apt_fail, rct_fail};
                        end else if (state == ST_STARTUP) begin
                            su_cnt <= su_cnt_n;
                            if (su_cnt_n == 8'(STARTUP)) begin
                                state <= ST_RUN;
                            end
                        end
                    end
                end
                ST_FAIL: begin
                    if (clear_fail) begin
                        state       <= ST_STARTUP;
                        health_fail <= 1'b0;
                        fail_code   <= 2'b00;
                        rct_cnt     <= 4'd0;
                        su_cnt      <= 8'd0;
                    end
                end
                default: state <= ST_STARTUP;
            endcase
        end
    end
endmodule

// File: tb/tb_ttrng_sampler.sv
// Scoreboard bench for ttrng_sampler: stimulus queues expected output bytes, a negedge monitor pops and compares them.
module tb_ttrng_sampler;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] number;
    logic       number_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       health_fail;
    logic [1:0] fail_code;
    logic       overrun;
    logic       clear_fail;

    logic [7:0] exp_q[$];
    logic [7:0] exp_b;
    int         checks = 0;
    int         errors = 0;

`ifdef TTRNG_APT_EN
    localparam bit APT_ON = 1'b1;
`else
    localparam bit APT_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    ttrng_sampler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .number      (number),
        .number_valid(number_valid),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .health_fail (health_fail),
        .fail_code   (fail_code),
        .overrun     (overrun),
        .clear_fail  (clear_fail)
    );

    // Every handshake seen at the negedge must match the oldest expected byte.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got out_data=%02h, expected no output", out_data);
            end else begin
                exp_b = exp_q.pop_front();
                if (out_data !== exp_b) begin
                    errors++;
                    $display("FAIL scoreboard_data: got %02h, expected %02h", out_data, exp_b);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] v);
        number       = v;
        number_valid = 1'b1;
        @(posedge clk);
        #1;
        number_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear_fail = 1'b1;
        tick();
        clear_fail = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] v;
        rst_n = 1'b0; ena = 1'b1; number = 8'h00; number_valid = 1'b0;
        out_ready = 1'b1; clear_fail = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_health_fail", 32'(health_fail), 0);
        chk("rst_fail_code", 32'(fail_code), 0);
        chk("rst_overrun", 32'(overrun), 0);
        rst_n = 1'b1;
        tick();

        // Startup: 16 distinct samples are consumed silently, the 17th comes out.
        for (int i = 0; i < 16; i++) begin
            send(8'(i));
            chk("startup_no_valid", 32'(out_valid), 0);
        end
        tick();
        chk("startup_end_no_valid", 32'(out_valid), 0);
        exp_q.push_back(8'hA5);
        send(8'hA5);
        chk("a5_staged_not_valid", 32'(out_valid), 0);
        tick();
        chk("a5_valid", 32'(out_valid), 1);
        chk("a5_data", 32'(out_data), 32'h A5);
        chk("a5_fail_code", 32'(fail_code), 0);
        tick();

        // RCT: five 0x3C in a row, four stored then the fifth fails and flushes.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h3C);
        repeat (5) send(8'h3C);
        chk("rct_four_stored", 32'(out_valid), 1);
        tick();
        chk("rct_health_fail", 32'(health_fail), 1);
        chk("rct_fail_code", 32'(fail_code), 32'h1);
        chk("rct_flushed", 32'(out_valid), 0);
        exp_q.delete();
        send(8'h99);
        tick();
        chk("fail_sticky", 32'(health_fail), 1);

        // Clear from FAIL: 16 more startup samples, then 0x55 is output.
        out_ready = 1'b1;
        pulse_clear();
        chk("clear_health_fail", 32'(health_fail), 0);
        chk("clear_fail_code", 32'(fail_code), 0);
        for (int i = 0; i < 16; i++) send(8'h40 + 8'(i));
        chk("restart_no_valid", 32'(out_valid), 0);
        exp_q.push_back(8'h55);
        send(8'h55);
        chk("restart_55_pre", 32'(out_valid), 0);
        tick();
        chk("restart_55_valid", 32'(out_valid), 1);
        chk("restart_55_data", 32'(out_data), 32'h55);
        tick();

        // Overrun: five pushes into a 4-deep FIFO with no pops.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h60 + 8'(i));
        for (int i = 0; i < 5; i++) send(8'h60 + 8'(i));
        tick();
        chk("ovr_overrun", 32'(overrun), 1);
        chk("ovr_valid", 32'(out_valid), 1);
        chk("ovr_head", 32'(out_data), 32'h60);
        tick();
        chk("ovr_head_stable", 32'(out_data), 32'h60);
        pulse_clear();
        chk("run_clear_overrun", 32'(overrun), 0);
        chk("run_clear_keeps_ok", 32'(health_fail), 0);
        // Pop and push together while full: no drop.
        exp_q.push_back(8'h65);
        send(8'h65);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("full_pop_push_no_drop", 32'(overrun), 0);
        chk("full_pop_push_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        repeat (6) tick();
        chk("drained_valid", 32'(out_valid), 0);
        chk("drained_queue", 32'(exp_q.size()), 0);

        // APT: 23 samples of the current window done; 41 fillers close it, next window starts with 0x77.
        for (int i = 0; i < 41; i++) begin
            v = 8'h80 + 8'(i);
            exp_q.push_back(v);
            send(v);
        end
        for (int k = 0; k < 49; k++) begin
            v = (k % 4 == 0) ? 8'h77 : 8'hC0 + 8'(k);
            if (!(APT_ON && k == 48)) exp_q.push_back(v);
            send(v);
        end
        tick();
        chk("apt_health_fail", 32'(health_fail), 32'(APT_ON));
        chk("apt_fail_code", 32'(fail_code), APT_ON ? 32'h2 : 32'h0);
        repeat (3) tick();
        chk("apt_queue_drained", 32'(exp_q.size()), 0);
        chk("apt_out_valid", 32'(out_valid), 0);

        if (APT_ON) begin
            pulse_clear();
            for (int i = 0; i < 16; i++) send(8'hD0 + 8'(i));
            tick();
        end

        // Asynchronous reset with three bytes held.
        out_ready = 1'b0;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        tick();
        chk("pre_reset_valid", 32'(out_valid), 1);
        chk("pre_reset_head", 32'(out_data), 32'h11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 0);
        chk("async_rst_data", 32'(out_data), 0);
        chk("async_rst_health_fail", 32'(health_fail), 0);
        chk("async_rst_fail_code", 32'(fail_code), 0);
        chk("async_rst_overrun", 32'(overrun), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
